snapshot_capture_ctrl: RTL
==========================

SNAPSHOT_CAPTURE_CTRL -- requirements
Module: snapshot_capture_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of captured sample and BRAM data port.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, BRAM address width; capture depth N = 2^ADDR_WIDTH words.
REQ-003 SHALL use exactly one clock and an asynchronous, active-high reset: OPB_Clk input 1, the only clock; OPB_Rst input 1, asynchronous active-high reset.
REQ-004 SHALL have ctrl_word, input, 32: software control register; bit0 arm, bit1 trig_sel (0 immediate, 1 external), bit2 we_sel (0 every cycle, 1 gated by din_valid), bit3 abort; other bits ignored.
REQ-005 SHALL have din, input, DATA_WIDTH: sample to capture.
REQ-006 SHALL have din_valid, input, 1: sample qualifier, used when we_sel=1.
REQ-007 SHALL have ext_trig, input, 1: external trigger, level-sampled.
REQ-008 SHALL have bram_addr, output, ADDR_WIDTH: BRAM write address.
REQ-009 SHALL have bram_data, output, DATA_WIDTH: BRAM write data.
REQ-010 SHALL have bram_we, output, 1: BRAM write enable.
REQ-011 SHALL have status_word, output, 32: bit0 done, bit1 busy, bit2 armed, bits[31:16] captured word count, bits[15:3] zero.

Function
REQ-012 SHALL detect an arm request as a 0->1 transition of ctrl_word[0] between consecutive OPB_Clk cycles; a held level SHALL NOT re-arm.
REQ-013 SHALL implement states IDLE, ARMED, CAPTURE, DONE.
REQ-014 IDLE: on arm edge go to ARMED; clear done and count that same cycle.
REQ-015 ARMED: if trig_sel=0 go to CAPTURE next cycle; if trig_sel=1 go to CAPTURE the cycle after ext_trig is sampled high.
REQ-016 CAPTURE: a write qualifies each cycle when we_sel=0, or when din_valid=1 if we_sel=1.
REQ-017 Each qualified sample SHALL appear on bram_data with bram_we=1 exactly one cycle after din/din_valid sampled (one-register pipeline), bram_addr equal to the count of prior qualified writes.
REQ-018 After the N-th qualified write is issued (address N-1), SHALL go to DONE; no further bram_we; address SHALL NOT wrap.
REQ-019 DONE: done=1, busy=0; stays until the next arm edge, which behaves as REQ-014 (re-arm from DONE permitted).
REQ-020 Count field SHALL saturate at N and report min(count, 65535).
REQ-021 abort=1 in ARMED or CAPTURE SHALL return to IDLE next cycle, suppress any write not yet issued, keep count as-is, done=0; abort has priority over trigger and arm.
REQ-022 Arm edge while in ARMED or CAPTURE SHALL be ignored.
REQ-023 trig_sel and we_sel SHALL be sampled every cycle (no latching); changing them mid-capture takes effect next cycle.
REQ-024 busy SHALL be 1 in ARMED and CAPTURE; armed SHALL be 1 only in ARMED.
REQ-025 ext_trig high and abort high in the same ARMED cycle SHALL give IDLE.

Reset
REQ-026 OPB_Rst high SHALL immediately force IDLE, bram_we=0, bram_addr=0, bram_data=0, status_word=0, arm edge-detect history=0, independent of OPB_Clk.
REQ-027 Reset asserted mid-capture SHALL abort with no further writes; after release a held ctrl_word[0]=1 SHALL NOT arm until it returns to 0 and rises again.

Verification
REQ-028 Immediate mode, we_sel=0, ADDR_WIDTH=4: arm edge -> 16 consecutive bram_we pulses, addr 0..15, data = din one cycle late, then status_word=0x00100001.
REQ-029 External trigger: trig_sel=1, arm, hold ext_trig low 50 cycles -> status armed=1, no writes; pulse ext_trig -> capture starts next cycle.
REQ-030 Gated writes: we_sel=1, din_valid every 3rd cycle -> writes only on valid samples, addresses contiguous, count reaches 16 after 48 cycles.
REQ-031 Abort at count 5 -> exactly 5 writes, state IDLE, status_word=0x00050000; fresh arm edge restarts at addr 0.
REQ-032 Asynchronous reset at count 7 with arm held high -> outputs 0 without clock edge; after release no capture until arm toggles 0->1.
REQ-033 Re-arm from DONE and arm held high during CAPTURE -> held level ignored, only new edges re-arm; done cleared on re-arm.

Source files
------------

// File: rtl/snapshot_capture_ctrl.sv
// Snapshot capture controller: arms on a rising ctrl_word[0], waits for an immediate or external
// trigger, then streams N qualified samples into BRAM through a one-register write pipeline.
module snapshot_capture_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  OPB_Clk,
    input  logic                  OPB_Rst,
    input  logic [31:0]           ctrl_word,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_valid,
    input  logic                  ext_trig,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_data,
    output logic                  bram_we,
    output logic [31:0]           status_word
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] LAST_IDX = {1'b0, {ADDR_WIDTH{1'b1}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          arm_prev;
    logic          hist_vld;
    logic          arm_edge;
    logic          abort;
    logic          trig_sel;
    logic          we_sel;
    logic          qual;
    logic          wr_issue;
    logic [31:0]   count_ext;
    logic [15:0]   count_field;
    logic          unused_ctrl;

    assign abort       = ctrl_word[3];
    assign trig_sel    = ctrl_word[1];
    assign we_sel      = ctrl_word[2];
    assign unused_ctrl = ^ctrl_word[31:4];
    assign qual        = we_sel ? din_valid : 1'b1;

    // hist_vld blocks a level that was already high across reset from looking like an edge.
    assign arm_edge = hist_vld & ctrl_word[0] & ~arm_prev;

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        wr_issue  = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (arm_edge && !abort) begin
                    state_nxt = ST_ARMED;
                    count_nxt = '0;
                end
            end
            ST_ARMED: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (!trig_sel || ext_trig) begin
                    state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (qual) begin
                    wr_issue  = 1'b1;
                    count_nxt = count + 1'b1;
                    if (count == LAST_IDX) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            state     <= ST_IDLE;
            count     <= '0;
            arm_prev  <= 1'b0;
            hist_vld  <= 1'b0;
            bram_we   <= 1'b0;
            bram_addr <= '0;
            bram_data <= '0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            arm_prev <= ctrl_word[0];
            hist_vld <= 1'b1;
            bram_we  <= wr_issue;
            if (wr_issue) begin
                bram_addr <= count[ADDR_WIDTH-1:0];
                bram_data <= din;
            end
        end
    end

    // Count field saturates at 16 bits for deep configurations.
    assign count_ext   = 32'(count);
    assign count_field = (count_ext > 32'd65535) ? 16'hFFFF : count_ext[15:0];

    assign status_word = {count_field, 13'd0,
                          state == ST_ARMED,
                          (state == ST_ARMED) || (state == ST_CAPTURE),
                          state == ST_DONE};

endmodule
